// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   state_t        : controller states (IDLE, SHIFT, DONE)
//   DEFAULT_WIDTH  : default operand/result width
//   cnt_width()    : bit counter width for a given operand width
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Counter must hold WIDTH-1 without wrapping; never narrower than 1 bit.
  function automatic int cnt_width(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/full_subtractor_cell.sv
// Combinational one-bit full subtractor: d = a - b - bin, with borrow out.
// Built from two half-subtractor stages whose borrows are ORed.
// Ports:
//   a, b  : minuend and subtrahend bits
//   bin   : borrow in
//   d     : difference bit
//   bout  : borrow out
module full_subtractor_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic d1;
  logic b1;
  logic b2;

  // Stage 1: a - b
  assign d1 = a ^ b;
  assign b1 = ~a & b;

  // Stage 2: (a - b) - bin
  assign d  = d1 ^ bin;
  assign b2 = ~d1 & bin;

  assign bout = b1 | b2;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: D = A - B, LSB first, one bit per
// clock through a single full-subtractor cell and a borrow flop.
// Optional macro SERIAL_SUBTRACTOR_SIGNED_EN adds the signed-overflow output V.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid / in_ready : operand handshake (A minuend, B subtrahend)
//   out_valid/out_ready : result handshake
//   D                   : difference modulo 2^WIDTH
//   Bout                : final borrow (1 when unsigned A < B)
//   V                   : signed overflow (only with SERIAL_SUBTRACTOR_SIGNED_EN)
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             Bout
`ifdef SERIAL_SUBTRACTOR_SIGNED_EN
  ,
  output logic             V
`endif
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] d_sr;
  logic             borrow;
  logic             bout_r;
  logic [CW-1:0]    cnt;

  logic load;
  logic shift_en;
  logic last_shift;
  logic d_bit;
  logic br_next;

  // ---------------------------------------------------------------------
  // Controller
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values,
    // independent of the order the always blocks are evaluated in.
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    // NOTE: every output gets a default before the case, so no path leaves
    // a signal unassigned and no latch is inferred.
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    load       = 1'b0;
    shift_en   = 1'b0;
    last_shift = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load       = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        // This cycle's shift produces the MSB of the result.
        if (cnt == LAST) begin
          last_shift = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------
  full_subtractor_cell u_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (borrow),
    .d    (d_bit),
    .bout (br_next)
  );

  always_ff @(posedge clk) begin
    // NOTE: the shift registers are reset as well, because D is visible on
    // the port and must read zero after reset.
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      d_sr   <= '0;
      borrow <= 1'b0;
      bout_r <= 1'b0;
      cnt    <= '0;
    end else if (load) begin
      a_sr   <= A;
      b_sr   <= B;
      borrow <= 1'b0;
      cnt    <= '0;
    end else if (shift_en) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      d_sr   <= {d_bit, d_sr[WIDTH-1:1]};
      borrow <= br_next;
      cnt    <= cnt + CW'(1);
      if (last_shift) bout_r <= br_next;
    end
  end

  assign D    = d_sr;
  assign Bout = bout_r;

`ifdef SERIAL_SUBTRACTOR_SIGNED_EN
  logic a_msb;
  logic b_msb;
  logic v_r;

  // Overflow when the operand signs differ and the result sign differs from
  // A; d_bit on the last shift is the result MSB.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      v_r   <= 1'b0;
    end else if (load) begin
      a_msb <= A[WIDTH-1];
      b_msb <= B[WIDTH-1];
    end else if (last_shift) begin
      v_r <= (a_msb ^ b_msb) & (d_bit ^ a_msb);
    end
  end

  assign V = v_r;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH = 8).
// Define SERIAL_SUBTRACTOR_SIGNED_EN to also exercise the V output.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] d;
  logic         bout;
`ifdef SERIAL_SUBTRACTOR_SIGNED_EN
  logic         v;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a),
    .B         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .D         (d),
    .Bout      (bout)
`ifdef SERIAL_SUBTRACTOR_SIGNED_EN
    ,
    .V         (v)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Step past the next rising edge; inputs are driven and outputs sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for out_valid with a cycle budget; n is the number of edges waited.
  task automatic wait_valid(input string tag, input int budget, output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
  endtask

  // Full transaction with out_ready high: accept, latency, result, handshake.
  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] exp_d, input logic exp_b);
    int n;
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_valid(tag, 20, n);
    check({tag, "_latency"}, n, W);
    check({tag, "_d"}, {24'd0, d}, {24'd0, exp_d});
    check({tag, "_bout"}, {31'd0, bout}, {31'd0, exp_b});
`ifdef SERIAL_SUBTRACTOR_SIGNED_EN
    check({tag, "_v"}, {31'd0, v},
          {31'd0, (av[W-1] != bv[W-1]) && (exp_d[W-1] != av[W-1])});
`endif
    tick();
    check({tag, "_done_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_done_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    repeat (2) tick();
    rst_n = 1'b1;

    // Reset values
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_d",         {24'd0, d},         32'd0);
    check("rst_bout",      {31'd0, bout},      32'd0);

    // Basic and borrow cases
    run_op("basic",   8'h5A, 8'h23, 8'h37, 1'b0);
    run_op("borrow",  8'h10, 8'h20, 8'hF0, 1'b1);
    run_op("zero",    8'h00, 8'h00, 8'h00, 1'b0);
    run_op("ff_m_1",  8'hFF, 8'h01, 8'hFE, 1'b0);

    // Back-pressure: hold result for 5 cycles, new operands offered meanwhile
    out_ready = 1'b0;
    a         = 8'h10;
    b         = 8'h20;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_valid("bp", 20, n);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      a        = 8'h77;
      b        = 8'h11;
      tick();
      check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      check("bp_hold_d",     {24'd0, d},         32'hF0);
      check("bp_hold_bout",  {31'd0, bout},      32'd1);
      check("bp_hold_ready", {31'd0, in_ready},  32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_release_valid", {31'd0, out_valid}, 32'd0);
    check("bp_release_ready", {31'd0, in_ready},  32'd1);
    tick();
    check("bp_single_hs", {31'd0, out_valid}, 32'd0);

    // Reset during the third shift cycle
    a        = 8'h5A;
    b        = 8'h23;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_d",     {24'd0, d},         32'd0);
    check("mid_rst_ready", {31'd0, in_ready},  32'd1);
    check("mid_rst_bout",  {31'd0, bout},      32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("mid_rst_no_pulse", {31'd0, out_valid}, 32'd0);
    end
    run_op("after_rst", 8'h03, 8'h05, 8'hFE, 1'b1);

    // Operand changes and in_valid toggling during SHIFT are ignored
    a        = 8'hC3;
    b        = 8'h3C;
    in_valid = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      in_valid = ~in_valid;
      a        = W'($urandom);
      b        = W'($urandom);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
    end
    in_valid = 1'b0;
    wait_valid("hold", 20, n);
    check("hold_d",    {24'd0, d},    32'h87);
    check("hold_bout", {31'd0, bout}, 32'd0);
    tick();

    // Back-to-back random stream against a reference model
    for (int i = 0; i < 16; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      run_op("rand", ra, rb, ra - rb, (ra < rb));
    end

`ifdef SERIAL_SUBTRACTOR_SIGNED_EN
    run_op("sgn_80_01", 8'h80, 8'h01, 8'h7F, 1'b0);
    check("sgn_80_01_v1", {31'd0, v}, 32'd1);
    run_op("sgn_7f_ff", 8'h7F, 8'hFF, 8'h80, 1'b1);
    check("sgn_7f_ff_v1", {31'd0, v}, 32'd1);
    run_op("sgn_05_03", 8'h05, 8'h03, 8'h02, 1'b0);
    check("sgn_05_03_v0", {31'd0, v}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
